wb_slave_mem: RTL and testbench



---
 rtl/wb_slave_mem_if.sv | 28 ++
 rtl/wb_slave_mem.sv | 160 ++++++++++++++++
 tb/tb_wb_slave_mem.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic-cycle bus bundle between a master and wb_slave_mem.
// Signal names follow the Wishbone datasheet naming used by the SoC (DAT_I/DAT_O
// are seen from the slave side).
interface wb_slave_mem_if;
    logic [31:0] p_wb_DAT_I;
    logic [31:0] p_wb_DAT_O;
    logic [31:0] p_wb_ADR_I;
    logic        p_wb_ACK_O;
    logic        p_wb_CYC_I;
    logic        p_wb_ERR_O;
    logic        p_wb_LOCK_I;
    logic        p_wb_RTY_O;
    logic [3:0]  p_wb_SEL_I;
    logic        p_wb_STB_I;
    logic        p_wb_WE_I;

    modport slave (
        input  p_wb_DAT_I, p_wb_ADR_I, p_wb_CYC_I, p_wb_LOCK_I,
               p_wb_SEL_I, p_wb_STB_I, p_wb_WE_I,
        output p_wb_DAT_O, p_wb_ACK_O, p_wb_ERR_O, p_wb_RTY_O
    );

    modport master (
        output p_wb_DAT_I, p_wb_ADR_I, p_wb_CYC_I, p_wb_LOCK_I,
               p_wb_SEL_I, p_wb_STB_I, p_wb_WE_I,
        input  p_wb_DAT_O, p_wb_ACK_O, p_wb_ERR_O, p_wb_RTY_O
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave backed by an on-chip word memory.
// A request seen in IDLE waits WAIT_STATES cycles, then registers exactly one
// termination pulse (ACK, ERR or RTY) and returns to IDLE. Addresses outside the
// window or not word-aligned terminate with ERR and touch nothing.
// Optional feature macro: WB_SLAVE_MEM_RETRY_EN adds p_mem_busy; a valid access
// that finds the memory busy terminates with RTY instead of ACK. Without the
// macro RTY is tied low.
module wb_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic          p_clk,
    input  logic          p_resetn,
`ifdef WB_SLAVE_MEM_RETRY_EN
    input  logic          p_mem_busy,
`endif
    wb_slave_mem_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // End of the window computed one bit wider so a window touching 2^32 cannot wrap.
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + (33'(MEM_WORDS) << 2);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      dat_q, dat_d;
`ifdef WB_SLAVE_MEM_RETRY_EN
    logic             rty_q, rty_d;
`endif

    logic [31:0]      mem_q [MEM_WORDS];
    logic             mem_we;
    logic             req;
    logic             addr_valid;
    logic [IDX_W-1:0] mem_idx;

    // LOCK only matters to interconnect arbitration; this slave has nothing to lock.
    logic             lock_unused;
    assign lock_unused = bus.p_wb_LOCK_I;

    assign req        = bus.p_wb_CYC_I & bus.p_wb_STB_I;
    assign addr_valid = (bus.p_wb_ADR_I[1:0] == 2'b00)
                     && (bus.p_wb_ADR_I >= ADDR_BASE)
                     && ({1'b0, bus.p_wb_ADR_I} < ADDR_END);
    assign mem_idx    = IDX_W'((bus.p_wb_ADR_I - ADDR_BASE) >> 2);

    // Next-state and response decode; bus inputs are taken in the RESP cycle itself.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        mem_we  = 1'b0;
`ifdef WB_SLAVE_MEM_RETRY_EN
        rty_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (req) begin
                    if (!addr_valid) begin
                        err_d = 1'b1;
`ifdef WB_SLAVE_MEM_RETRY_EN
                    end else if (p_mem_busy) begin
                        rty_d = 1'b1;
`endif
                    end else begin
                        ack_d = 1'b1;
                        if (bus.p_wb_WE_I) begin
                            mem_we = 1'b1;
                        end else begin
                            dat_d = mem_q[mem_idx];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and registered bus outputs, cleared asynchronously on reset.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
`ifdef WB_SLAVE_MEM_RETRY_EN
            rty_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // sees the pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
`ifdef WB_SLAVE_MEM_RETRY_EN
            rty_q   <= rty_d;
`endif
        end
    end

    // Byte-lane write into the word array on the ACK edge.
    // NOTE: the array has no reset so it maps onto plain RAM; reset holds the FSM
    // in IDLE, which keeps mem_we low and drops any pending write.
    always_ff @(posedge p_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.p_wb_SEL_I[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= bus.p_wb_DAT_I[8*b +: 8];
                end
            end
        end
    end

    assign bus.p_wb_ACK_O = ack_q;
    assign bus.p_wb_ERR_O = err_q;
    assign bus.p_wb_DAT_O = dat_q;
`ifdef WB_SLAVE_MEM_RETRY_EN
    assign bus.p_wb_RTY_O = rty_q;
`else
    assign bus.p_wb_RTY_O = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem (default parameters, WAIT_STATES = 1).
// A transaction-level model schedules, for each beat, the cycle on which its
// termination must appear and what DAT_O must hold; a compare process checks
// all four outputs against it on every falling edge. Retry scenarios are built
// only when WB_SLAVE_MEM_RETRY_EN is defined.
module tb_wb_slave_mem;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          WORDS = 256;
    localparam int          WS    = 1;

    typedef struct {
        longint      cyc;
        logic        ack;
        logic        err;
        logic        rty;
        logic        rd;
        logic [31:0] d;
    } ev_t;

    logic p_clk = 1'b0;
    logic p_resetn = 1'b0;
    logic mem_busy = 1'b0;

    wb_slave_mem_if bus_if ();

    wb_slave_mem #(
        .ADDR_BASE  (BASE),
        .MEM_WORDS  (WORDS),
        .WAIT_STATES(WS)
    ) dut (
        .p_clk     (p_clk),
        .p_resetn  (p_resetn),
`ifdef WB_SLAVE_MEM_RETRY_EN
        .p_mem_busy(mem_busy),
`endif
        .bus       (bus_if.slave)
    );

    always #5 p_clk = ~p_clk;

    longint cyc_cnt = 0;
    always @(posedge p_clk) cyc_cnt <= cyc_cnt + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] model_mem [int];
    logic [31:0] model_dat = 32'h0;
    ev_t         evq [$];
    bit          checking = 1'b0;

    function automatic bit addr_ok(input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        return (a[1:0] == 2'b00) && (off >= 0) && (off < 4 * WORDS);
    endfunction

    // Predict the outcome of one beat whose request is first seen at cycle n.
    task automatic schedule(input longint n, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] sel);
        ev_t         ev;
        logic [31:0] mask;
        int          w;
        ev.cyc = n + 1 + WS;
        ev.ack = 1'b0; ev.err = 1'b0; ev.rty = 1'b0; ev.rd = 1'b0; ev.d = '0;
        if (!addr_ok(a)) begin
            ev.err = 1'b1;
        end else if (mem_busy) begin
            ev.rty = 1'b1;
        end else begin
            ev.ack = 1'b1;
            w = int'((a - BASE) / 4);
            if (we) begin
                mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                model_mem[w] = (model_mem[w] & ~mask) | (wd & mask);
            end else begin
                ev.rd = 1'b1;
                ev.d  = model_mem[w];
            end
        end
        evq.push_back(ev);
    endtask

    // Per-cycle comparison of every output against the model.
    logic cmp_ack, cmp_err, cmp_rty;
    ev_t  cmp_ev;
    always @(negedge p_clk) begin
        if (checking) begin
            cmp_ack = 1'b0; cmp_err = 1'b0; cmp_rty = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc_cnt) begin
                cmp_ev  = evq.pop_front();
                cmp_ack = cmp_ev.ack;
                cmp_err = cmp_ev.err;
                cmp_rty = cmp_ev.rty;
                if (cmp_ev.rd) model_dat = cmp_ev.d;
            end
            check("ack_o", {31'h0, bus_if.p_wb_ACK_O}, {31'h0, cmp_ack});
            check("err_o", {31'h0, bus_if.p_wb_ERR_O}, {31'h0, cmp_err});
            check("rty_o", {31'h0, bus_if.p_wb_RTY_O}, {31'h0, cmp_rty});
            check("dat_o", bus_if.p_wb_DAT_O, model_dat);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the terminating edge.
    task automatic beat(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, input bit keep,
                        output logic [31:0] rd, output int lat);
        longint c0;
        bit     got;
        c0 = cyc_cnt;
        bus_if.p_wb_CYC_I = 1'b1;
        bus_if.p_wb_STB_I = 1'b1;
        bus_if.p_wb_WE_I  = we;
        bus_if.p_wb_ADR_I = a;
        bus_if.p_wb_DAT_I = wd;
        bus_if.p_wb_SEL_I = sel;
        schedule(c0 + 1, we, a, wd, sel);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge p_clk);
            #1;
            if (bus_if.p_wb_ACK_O || bus_if.p_wb_ERR_O || bus_if.p_wb_RTY_O) got = 1'b1;
        end
        if (!got) check("term_timeout", {31'h0, bus_if.p_wb_ACK_O}, 32'h1);
        lat = int'(cyc_cnt - (c0 + 1));
        rd  = bus_if.p_wb_DAT_O;
        if (!keep) begin
            bus_if.p_wb_CYC_I = 1'b0;
            bus_if.p_wb_STB_I = 1'b0;
            bus_if.p_wb_WE_I  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge p_clk);
        #1;
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        bus_if.p_wb_CYC_I  = 1'b0;
        bus_if.p_wb_STB_I  = 1'b0;
        bus_if.p_wb_WE_I   = 1'b0;
        bus_if.p_wb_LOCK_I = 1'b0;
        bus_if.p_wb_ADR_I  = '0;
        bus_if.p_wb_DAT_I  = '0;
        bus_if.p_wb_SEL_I  = '0;

        // Reset values.
        repeat (3) @(posedge p_clk);
        #1;
        check("rst_ack", {31'h0, bus_if.p_wb_ACK_O}, 32'h0);
        check("rst_err", {31'h0, bus_if.p_wb_ERR_O}, 32'h0);
        check("rst_rty", {31'h0, bus_if.p_wb_RTY_O}, 32'h0);
        check("rst_dat", bus_if.p_wb_DAT_O, 32'h0);
        #1 p_resetn = 1'b1;
        checking = 1'b1;
        idle(2);

        // Single write and readback, two-cycle latency with LOCK asserted.
        bus_if.p_wb_LOCK_I = 1'b1;
        beat(1'b1, 32'h1000_0010, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat);
        check("wr_latency", lat, 32'd2);
        bus_if.p_wb_LOCK_I = 1'b0;
        idle(1);
        beat(1'b0, 32'h1000_0010, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rd_latency", lat, 32'd2);
        check("rd_cafe", rd, 32'hCAFE_F00D);
        idle(1);

        // Byte-lane write, then SEL=0 write that must change nothing.
        beat(1'b1, 32'h1000_0020, 32'h1122_3344, 4'hF, 1'b0, rd, lat);
        beat(1'b1, 32'h1000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, lat);
        beat(1'b0, 32'h1000_0020, 32'h0, 4'h1, 1'b0, rd, lat);
        check("rd_lanes", rd, 32'h11BB_33DD);
        beat(1'b1, 32'h1000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, lat);
        beat(1'b0, 32'h1000_0020, 32'h0, 4'hF, 1'b0, rd, lat);
        check("rd_sel0", rd, 32'h11BB_33DD);
        idle(2);

        // Block write then block read with STB held between beats.
        for (int i = 0; i < 8; i++)
            beat(1'b1, BASE + 32'(4 * i), 32'(i), 4'hF, i < 7, rd, lat);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            beat(1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, i < 7, rd, lat);
            check("blk_rd", rd, 32'(i));
        end
        idle(2);

        // Bad addresses: below window, one past the end, misaligned.
        beat(1'b1, 32'h0FFF_FFFC, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat);
        beat(1'b1, 32'h1000_0400, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat);
        beat(1'b1, 32'h1000_0002, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat);
        beat(1'b0, 32'h1000_0400, 32'h0, 4'hF, 1'b0, rd, lat);
        check("err_dat_hold", rd, 32'h7);
        beat(1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b0, rd, lat);
        check("err_nowrite0", rd, 32'h0);
        beat(1'b0, 32'h1000_03FC, 32'h0, 4'hF, 1'b0, rd, lat);
        idle(1);

        // Abort: STB dropped while the slave is waiting.
        beat(1'b1, 32'h1000_0030, 32'h1234_5678, 4'hF, 1'b0, rd, lat);
        bus_if.p_wb_CYC_I = 1'b1;
        bus_if.p_wb_STB_I = 1'b1;
        bus_if.p_wb_WE_I  = 1'b1;
        bus_if.p_wb_ADR_I = 32'h1000_0030;
        bus_if.p_wb_DAT_I = 32'h5;
        bus_if.p_wb_SEL_I = 4'hF;
        idle(1);
        bus_if.p_wb_STB_I = 1'b0;
        idle(4);
        bus_if.p_wb_CYC_I = 1'b0;
        bus_if.p_wb_WE_I  = 1'b0;
        beat(1'b0, 32'h1000_0030, 32'h0, 4'hF, 1'b0, rd, lat);
        check("abort_nowrite", rd, 32'h1234_5678);
        idle(1);

        // Reset in the middle of a wait: outputs clear before any clock edge.
        bus_if.p_wb_CYC_I = 1'b1;
        bus_if.p_wb_STB_I = 1'b1;
        bus_if.p_wb_WE_I  = 1'b1;
        bus_if.p_wb_ADR_I = 32'h1000_0030;
        bus_if.p_wb_DAT_I = 32'h99;
        idle(1);
        #1;
        p_resetn = 1'b0;
        evq.delete();
        model_dat = 32'h0;
        #1;
        check("async_ack", {31'h0, bus_if.p_wb_ACK_O}, 32'h0);
        check("async_err", {31'h0, bus_if.p_wb_ERR_O}, 32'h0);
        check("async_dat", bus_if.p_wb_DAT_O, 32'h0);
        bus_if.p_wb_CYC_I = 1'b0;
        bus_if.p_wb_STB_I = 1'b0;
        bus_if.p_wb_WE_I  = 1'b0;
        repeat (2) @(posedge p_clk);
        #2 p_resetn = 1'b1;
        idle(1);
        beat(1'b0, 32'h1000_0030, 32'h0, 4'hF, 1'b0, rd, lat);
        check("rst_dropped_wr", rd, 32'h1234_5678);
        idle(1);

`ifdef WB_SLAVE_MEM_RETRY_EN
        // Retry while busy, error beats retry, then a clean retry succeeds.
        beat(1'b1, 32'h1000_0040, 32'h0000_0001, 4'hF, 1'b0, rd, lat);
        mem_busy = 1'b1;
        beat(1'b1, 32'h1000_0040, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, lat);
        check("rty_seen", {31'h0, bus_if.p_wb_RTY_O}, 32'h1);
        beat(1'b1, 32'h1000_0400, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, lat);
        check("err_over_rty", {31'h0, bus_if.p_wb_ERR_O}, 32'h1);
        mem_busy = 1'b0;
        beat(1'b0, 32'h1000_0040, 32'h0, 4'hF, 1'b0, rd, lat);
        check("rty_nowrite", rd, 32'h0000_0001);
        beat(1'b1, 32'h1000_0040, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, lat);
        beat(1'b0, 32'h1000_0040, 32'h0, 4'hF, 1'b0, rd, lat);
        check("rty_then_ack", rd, 32'hA5A5_5A5A);
        idle(1);
`endif

        idle(4);
        if (evq.size() != 0) check("pending_events", 32'(evq.size()), 32'h0);
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
